// File: rtl/yarp_pkg.sv
// Shared types for the yarp core memory-side blocks.
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RSP
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/yarp_arb_starve_ctr.sv
// Saturating count of consecutive arbitrations the IFU lost to the LSU.
// ifu_force tells the arbiter that a pending IFU request must win next time.
module yarp_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,    // an arbitration decision is taken this cycle
    input  logic ifu_pend,  // IFU was requesting at that decision
    input  logic lsu_win,   // LSU won that decision
    output logic ifu_force
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    // Count IFU losses, clear whenever the IFU wins or is not asking.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (arb_en) begin
            if (ifu_pend && lsu_win) begin
                if (cnt != CW'(STARVE_MAX)) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign ifu_force = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction in flight; LSU has priority unless the IFU is starving.
module yarp_mem_arbiter
    import yarp_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req_i,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    output logic              ifu_gnt_o,
    output logic              ifu_rvalid_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    input  logic              lsu_req_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic              lsu_wr_i,
    input  logic [1:0]        lsu_size_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic [1:0]        mem_size_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              proto_err_o
);
    arb_state_t state, state_d;
    arb_owner_t owner;
    logic       load;
    logic       arb_pt, any_req, ifu_force, pick_lsu;
    logic       gnt_take, rsp_take, proto_evt;

    // An arbitration decision happens in IDLE and on the response cycle.
    assign arb_pt   = (state == ARB_IDLE) || (state == ARB_RSP && mem_rvalid_i);
    assign any_req  = ifu_req_i || lsu_req_i;
    assign pick_lsu = lsu_req_i && !(ifu_req_i && ifu_force);

    assign gnt_take  = (state == ARB_REQ) && mem_gnt_i;
    assign rsp_take  = (state == ARB_RSP) && mem_rvalid_i;
    // A response is only legal in RSP; a grant only in REQ. Same-cycle gnt+rvalid
    // in REQ therefore flags the rvalid.
    assign proto_evt = (mem_rvalid_i && state != ARB_RSP) || (mem_gnt_i && state != ARB_REQ);

    yarp_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk       (clk),
        .reset     (reset),
        .arb_en    (arb_pt),
        .ifu_pend  (ifu_req_i),
        .lsu_win   (any_req && pick_lsu),
        .ifu_force (ifu_force)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_d;
    end

    // Next state; re-arbitration on the response cycle goes straight to REQ.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        unique case (state)
            ARB_IDLE: if (any_req) begin
                load    = 1'b1;
                state_d = ARB_REQ;
            end
            ARB_REQ:  if (mem_gnt_i) state_d = ARB_RSP;
            ARB_RSP:  if (mem_rvalid_i) begin
                if (any_req) begin
                    load    = 1'b1;
                    state_d = ARB_REQ;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Owner and memory request registers; payload held from load until next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= OWN_IFU;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wr_o    <= 1'b0;
            mem_size_o  <= 2'b00;
            mem_wdata_o <= '0;
        end else if (load) begin
            owner       <= pick_lsu ? OWN_LSU : OWN_IFU;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= pick_lsu ? lsu_addr_i : ifu_addr_i;
            mem_wr_o    <= pick_lsu && lsu_wr_i;
            mem_size_o  <= pick_lsu ? lsu_size_i : WORD;
            mem_wdata_o <= pick_lsu ? lsu_wdata_i : '0;
        end else if (gnt_take) begin
            mem_req_o   <= 1'b0;
        end
    end

    // Sticky protocol error flag.
    always_ff @(posedge clk) begin
        if (reset)          proto_err_o <= 1'b0;
        else if (proto_evt) proto_err_o <= 1'b1;
    end

    // Handshakes routed to the latched owner; suppressed while reset is held.
    assign ifu_gnt_o    = !reset && gnt_take && owner == OWN_IFU;
    assign lsu_gnt_o    = !reset && gnt_take && owner == OWN_LSU;
    assign ifu_rvalid_o = !reset && rsp_take && owner == OWN_IFU;
    assign lsu_rvalid_o = !reset && rsp_take && owner == OWN_LSU;
    assign ifu_rdata_o  = mem_rdata_i;
    assign lsu_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Directed bench for yarp_mem_arbiter with an issue scoreboard.
module tb_yarp_mem_arbiter;
    import yarp_pkg::*;

    logic        clk, reset;
    logic        ifu_req_i, ifu_gnt_o, ifu_rvalid_o;
    logic [31:0] ifu_addr_i, ifu_rdata_o;
    logic        lsu_req_i, lsu_wr_i, lsu_gnt_o, lsu_rvalid_o;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic        mem_req_o, mem_wr_o, mem_gnt_i, mem_rvalid_i, proto_err_o;
    logic [1:0]  mem_size_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          lsu;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } exp_t;
    exp_t exp_q[$];

    yarp_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_wr_i(lsu_wr_i),
        .lsu_size_i(lsu_size_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o),
        .mem_size_o(mem_size_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .proto_err_o(proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit lsu, input logic [31:0] addr, input logic wr,
                        input logic [1:0] size, input logic [31:0] wdata);
        exp_t e;
        e.lsu = lsu; e.addr = addr; e.wr = wr; e.size = size; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    // Memory side: checks the issued request against the scoreboard, grants
    // after gdly cycles, responds one cycle after the grant.
    task automatic serve(input int gdly, input logic [31:0] rdata, input bit drop);
        exp_t e;
        int   n;
        n = 0;
        while (!mem_req_o && n < 50) begin step(); n++; end
        chk("mem_req_seen", {31'b0, mem_req_o}, 32'd1);
        if (exp_q.size() == 0) begin
            chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk("issue_addr", mem_addr_o, e.addr);
        chk("issue_wr", {31'b0, mem_wr_o}, {31'b0, e.wr});
        if (e.lsu) begin
            chk("issue_size", {30'b0, mem_size_o}, {30'b0, e.size});
            chk("issue_wdata", mem_wdata_o, e.wdata);
        end
        repeat (gdly) begin
            step();
            chk("hold_addr", mem_addr_o, e.addr);
        end
        mem_gnt_i = 1'b1;
        #1;
        chk("ifu_gnt", {31'b0, ifu_gnt_o}, {31'b0, !e.lsu});
        chk("lsu_gnt", {31'b0, lsu_gnt_o}, {31'b0, e.lsu});
        step();
        mem_gnt_i = 1'b0;
        if (drop) begin
            if (e.lsu) lsu_req_i = 1'b0;
            else       ifu_req_i = 1'b0;
        end
        chk("req_cleared", {31'b0, mem_req_o}, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        #1;
        chk("ifu_rvalid", {31'b0, ifu_rvalid_o}, {31'b0, !e.lsu});
        chk("lsu_rvalid", {31'b0, lsu_rvalid_o}, {31'b0, e.lsu});
        chk(e.lsu ? "lsu_rdata" : "ifu_rdata", e.lsu ? lsu_rdata_o : ifu_rdata_o, rdata);
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_req"},  {31'b0, mem_req_o}, 32'd0);
        chk({tag, "_addr"},     mem_addr_o, 32'd0);
        chk({tag, "_wr"},       {31'b0, mem_wr_o}, 32'd0);
        chk({tag, "_size"},     {30'b0, mem_size_o}, 32'd0);
        chk({tag, "_wdata"},    mem_wdata_o, 32'd0);
        chk({tag, "_gnts"},     {30'b0, ifu_gnt_o, lsu_gnt_o}, 32'd0);
        chk({tag, "_rvalids"},  {30'b0, ifu_rvalid_o, lsu_rvalid_o}, 32'd0);
        chk({tag, "_proto"},    {31'b0, proto_err_o}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ifu_req_i = 0; ifu_addr_i = '0;
        lsu_req_i = 0; lsu_addr_i = '0; lsu_wr_i = 0; lsu_size_i = 2'b00; lsu_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        step(); step();
        reset = 1'b0;
        #1;
        chk_idle_outputs("reset");

        // IFU alone, grant 2 cycles after request, response one later
        step();
        ifu_req_i = 1'b1; ifu_addr_i = 32'h0000_0100;
        push(1'b0, 32'h100, 1'b0, WORD, 32'h0);
        step();
        chk("ifu_issue_lat", {31'b0, mem_req_o}, 32'd1);
        chk("ifu_issue_addr", mem_addr_o, 32'h100);
        serve(2, 32'h0051_3093, 1'b1);

        // simultaneous: LSU store first, IFU back-to-back
        ifu_req_i = 1'b1; ifu_addr_i = 32'h104;
        lsu_req_i = 1'b1; lsu_addr_i = 32'h2000; lsu_wr_i = 1'b1;
        lsu_size_i = WORD; lsu_wdata_i = 32'hDEAD_BEEF;
        push(1'b1, 32'h2000, 1'b1, WORD, 32'hDEAD_BEEF);
        push(1'b0, 32'h104, 1'b0, WORD, 32'h0);
        step();
        serve(1, 32'h0, 1'b1);
        chk("b2b_req", {31'b0, mem_req_o}, 32'd1);
        chk("b2b_addr", mem_addr_o, 32'h104);
        serve(0, 32'h1111_2222, 1'b1);
        lsu_wr_i = 1'b0; lsu_wdata_i = '0;

        // starvation: four LSU loads, then the IFU is forced through
        ifu_req_i = 1'b1; ifu_addr_i = 32'h200;
        lsu_req_i = 1'b1; lsu_addr_i = 32'h4000; lsu_size_i = HALF_WORD;
        for (int i = 0; i < 4; i++) push(1'b1, 32'h4000, 1'b0, HALF_WORD, 32'h0);
        push(1'b0, 32'h200, 1'b0, WORD, 32'h0);
        step();
        for (int i = 0; i < 4; i++) serve(0, 32'hA000_0000 + 32'(i), 1'b0);
        lsu_req_i = 1'b0;
        chk("starve_ifu_addr", mem_addr_o, 32'h200);
        serve(1, 32'h0000_0013, 1'b1);
        chk("starve_cnt_clr", 32'(dut.u_starve.cnt), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // payload stability while grant is withheld
        lsu_req_i = 1'b1; lsu_addr_i = 32'h2000; lsu_size_i = WORD;
        push(1'b1, 32'h2000, 1'b0, WORD, 32'h0);
        step();
        lsu_addr_i = 32'h3000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stable_addr", mem_addr_o, 32'h2000);
        end
        serve(0, 32'h5A5A_5A5A, 1'b1);

        // reset while waiting for a response
        ifu_req_i = 1'b1; ifu_addr_i = 32'h300;
        step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0; ifu_req_i = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
        #1;
        chk("stray_rvalids", {30'b0, ifu_rvalid_o, lsu_rvalid_o}, 32'd0);
        step();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        chk("stray_rvalid_err", {31'b0, proto_err_o}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("err_cleared", {31'b0, proto_err_o}, 32'd0);

        // grant while idle: sticky error
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("idle_gnt_err", {31'b0, proto_err_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("err_sticky", {31'b0, proto_err_o}, 32'd1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("err_reset", {31'b0, proto_err_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
